// File: rtl/ysyx_22041207_ifu.sv
// ysyx_22041207_ifu -- instruction fetch unit.
//
// This unit fetches one 32-bit instruction at a time and keeps at most one
// memory request outstanding. Accepted responses go into a small FIFO
// instruction buffer that feeds decode. A redirect from execute flushes the
// buffer and restarts fetch at a word-aligned target. A response to a request
// that was issued before the redirect is dropped when it arrives.
//
// Parameters
//   XLEN     PC / address width
//   RESET_PC first fetch address after reset (truncated to XLEN bits)
//   MEM_W    memory response width, 32 or 64
//   DEPTH    instruction buffer entries (power of 2, >= 2)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   redirect_valid, redirect_pc      control-flow change from execute
//   mem_req_valid/addr/ready         fetch request handshake
//   mem_rsp_valid, mem_rsp_data      fetch response (always accepted)
//   inst_valid, inst, inst_pc        buffer head presented to decode
//   inst_ready                       decode accepts the head
module ysyx_22041207_ifu #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          MEM_W    = 64,
  parameter int          DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             mem_req_valid,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_rsp_valid,
  input  logic [MEM_W-1:0] mem_rsp_data,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  inst_pc,
  input  logic             inst_ready
);

  localparam int                PTR_W       = $clog2(DEPTH);
  localparam logic [PTR_W:0]    LP_DEPTH    = (PTR_W+1)'(DEPTH);
  localparam logic [XLEN-1:0]   LP_RESET_PC = RESET_PC[XLEN-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [XLEN-1:0]    r_fetch_pc;
  logic [XLEN-1:0]    r_req_pc;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W:0]     w_count_nxt;
  logic [31:0]        r_buf_inst [DEPTH];
  logic [XLEN-1:0]    r_buf_pc   [DEPTH];

  logic               w_req_fire;
  logic               w_wr;
  logic               w_rd;
  logic [31:0]        w_rsp_inst;
  logic [XLEN-1:0]    w_redirect_tgt;
  logic               w_unused;

  // The low two bits of the redirect target are forced to zero.
  assign w_redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused       = ^redirect_pc[1:0];

  // Reset masks every output so nothing leaks out while rst is held.
  assign mem_req_valid = !rst && (r_state == S_REQ);
  assign mem_req_addr  = rst ? '0 : r_fetch_pc;
  assign inst_valid    = !rst && (r_count != '0);
  assign inst          = rst ? '0 : r_buf_inst[r_rptr];
  assign inst_pc       = rst ? '0 : r_buf_pc[r_rptr];

  assign w_req_fire = mem_req_valid && mem_req_ready;
  assign w_rd       = inst_valid && inst_ready;
  // Only a response in WAIT belongs to a live request. Responses seen in any
  // other state (DROP, or a leftover from before a reset) are ignored.
  assign w_wr       = !rst && (r_state == S_WAIT) && mem_rsp_valid && !redirect_valid;

  assign w_count_nxt = r_count + (PTR_W+1)'(w_wr) - (PTR_W+1)'(w_rd);

  generate
    if (MEM_W == 64) begin : g_rsp64
      // Bit 2 of the request address selects the half of the doubleword.
      assign w_rsp_inst = r_req_pc[2] ? mem_rsp_data[MEM_W-1:32] : mem_rsp_data[31:0];
    end else begin : g_rsp32
      assign w_rsp_inst = mem_rsp_data[31:0];
    end
  endgenerate

  // ---- fetch FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (redirect_valid || (r_count < LP_DEPTH)) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (w_req_fire) w_state_nxt = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (redirect_valid)                w_state_nxt = S_REQ;
          else if (w_count_nxt < LP_DEPTH)   w_state_nxt = S_REQ;
          else                               w_state_nxt = S_IDLE;
        end else if (redirect_valid) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_rsp_valid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- control registers: state, fetch PC, buffer pointers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= LP_RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      // A redirect wins over the sequential increment.
      if (redirect_valid)  r_fetch_pc <= w_redirect_tgt;
      else if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (redirect_valid) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_wr) r_wptr <= r_wptr + 1'b1;
        if (w_rd) r_rptr <= r_rptr + 1'b1;
        r_count <= w_count_nxt;
      end
    end
  end

  // ---- data registers: request PC and buffer contents ----
  always_ff @(posedge clk) begin
    if (w_req_fire) r_req_pc <= r_fetch_pc;
    if (w_wr) begin
      r_buf_inst[r_wptr] <= w_rsp_inst;
      r_buf_pc[r_wptr]   <= r_req_pc;
    end
  end

endmodule
